// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD controller slice: state encoding, mux selects, datapath width.
package gcd_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_ITER   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic SEL_A    = 1'b0;
  localparam logic SEL_B    = 1'b1;
  localparam logic SEL_SUB  = 1'b0;
  localparam logic SEL_DATA = 1'b1;

endpackage

// File: rtl/gcd_iter_cnt.sv
// Subtraction-cycle counter with terminal-count flag at MAX_ITER.
// The count value is only exported when GCD_CYCLE_COUNT_EN is defined.
module gcd_iter_cnt
  import gcd_pkg::*;
#(
  parameter  int MAX_ITER = 65535,
  localparam int CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic at_max
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] count
`endif
);

  logic [CNT_W-1:0] cnt;

  // Saturates at MAX_ITER so the terminal flag cannot wrap back to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_max = (cnt == CNT_W'(MAX_ITER));

`ifdef GCD_CYCLE_COUNT_EN
  assign count = cnt;
`endif

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for the subtract-and-compare GCD datapath, with a timeout for zero operands.
// Define GCD_CYCLE_COUNT_EN to expose the final subtraction count on iter_count.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter  int MAX_ITER = 65535,
  localparam int CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic data_valid,
  input  logic gt,
  input  logic lt,
  input  logic eq,
  output logic ldA,
  output logic ldB,
  output logic sel1,
  output logic sel2,
  output logic sel_in,
  output logic busy,
  output logic done,
  output logic err
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] iter_count
`endif
);

  logic [2:0] state;
  logic [2:0] next_state;
  logic       cnt_clear;
  logic       cnt_inc;
  logic       at_max;
  logic       err_next;

  gcd_iter_cnt #(
    .MAX_ITER(MAX_ITER)
  ) u_iter_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .at_max(at_max)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .count (iter_count)
`endif
  );

  always_comb begin
    next_state = state;
    ldA        = 1'b0;
    ldB        = 1'b0;
    sel1       = SEL_A;
    sel2       = SEL_A;
    sel_in     = SEL_DATA;
    busy       = (state != S_IDLE);
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    err_next   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_LOAD_A;
      end
      S_LOAD_A: begin
        ldA = data_valid;
        if (data_valid) next_state = S_LOAD_B;
      end
      S_LOAD_B: begin
        ldB = data_valid;
        if (data_valid) begin
          cnt_clear  = 1'b1;
          next_state = S_ITER;
        end
      end
      S_ITER: begin
        // Equality wins over the timeout; an illegal no-flag cycle still burns an iteration.
        sel_in = SEL_SUB;
        if (eq) begin
          next_state = S_DONE;
        end else if (at_max) begin
          next_state = S_DONE;
          err_next   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
          if (gt) begin
            sel1 = SEL_A;
            sel2 = SEL_B;
            ldA  = 1'b1;
          end else if (lt) begin
            sel1 = SEL_B;
            sel2 = SEL_A;
            ldB  = 1'b1;
          end
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
    if (!rst_n) begin
      ldA = 1'b0;
      ldB = 1'b0;
    end
  end

  // done/err are registered so they coincide with the S_DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (next_state == S_DONE);
      err   <= (next_state == S_DONE) && err_next;
    end
  end

endmodule

// File: tb/tb_gcd_controller.sv
// Scoreboard bench for gcd_controller driving a behavioural GCD datapath model.
module tb_gcd_controller;
  import gcd_pkg::*;

  localparam int MAX_ITER = 8;
  localparam int CNT_W    = $clog2(MAX_ITER + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic data_valid;
  logic gt, lt, eq;
  logic ldA, ldB, sel1, sel2, sel_in, busy, done, err;
`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] iter_count;
`endif

  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] reg_a = '0;
  logic [DATA_W-1:0] reg_b = '0;
  logic [DATA_W-1:0] x_op, y_op, bus;

  typedef struct {
    int a;
    int b;
    int err;
    int cyc;
    int loads;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   loads  = 0;
  bit   busy_chk = 1'b0;

  always #5 clk = ~clk;

  gcd_controller #(
    .MAX_ITER(MAX_ITER)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_valid(data_valid),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq),
    .ldA       (ldA),
    .ldB       (ldB),
    .sel1      (sel1),
    .sel2      (sel2),
    .sel_in    (sel_in),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .iter_count(iter_count)
`endif
  );

  // Datapath model: X/Y muxes, subtractor, load-bus mux, A/B registers, comparator.
  assign x_op = sel1 ? reg_b : reg_a;
  assign y_op = sel2 ? reg_b : reg_a;
  assign bus  = sel_in ? data_in : (x_op - y_op);
  assign gt   = (reg_a > reg_b);
  assign lt   = (reg_a < reg_b);
  assign eq   = (reg_a == reg_b);

  always @(posedge clk) begin
    if (ldA) reg_a <= bus;
    if (ldB) reg_b <= bus;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: cycles and subtract loads are counted from the B accept edge; each done pops one entry.
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc      = 0;
      loads    = 0;
      busy_chk = 1'b0;
    end else begin
      if (busy_chk) begin
        checkOutput("busy_after_done", busy, 0);
        busy_chk = 1'b0;
      end
      if (ldB && sel_in) begin
        cyc   = 0;
        loads = 0;
      end else begin
        cyc++;
        if ((ldA || ldB) && !sel_in) loads++;
      end
      if (err && !done) checkOutput("err_without_done", err, 0);
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1, expected no done");
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("result_a", reg_a, e.a);
          checkOutput("result_b", reg_b, e.b);
          checkOutput("err_flag", err, e.err);
          checkOutput("done_latency", cyc, e.cyc);
          checkOutput("subtract_loads", loads, e.loads);
`ifdef GCD_CYCLE_COUNT_EN
          checkOutput("iter_count", iter_count, e.loads);
`endif
        end
        busy_chk = 1'b1;
      end
    end
  end

  // One operation: start pulse, operands with optional data_valid gaps, then wait for done.
  // A non-negative reset_after pulls rst_n low that many cycles into S_ITER instead.
  task automatic applyStimulus(input int a, input int b, input int wait_a, input int wait_b,
                               input int exp_a, input int exp_b, input int exp_err,
                               input int exp_cyc, input int exp_loads,
                               input bit poke_start, input int reset_after);
    bit   found;
    exp_t e;
    if (reset_after < 0) begin
      e.a = exp_a; e.b = exp_b; e.err = exp_err; e.cyc = exp_cyc; e.loads = exp_loads;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < wait_a; i++) begin
      data_valid = 1'b0;
      @(negedge clk);
      checkOutput("ldA_no_valid", ldA, 0);
      @(posedge clk); #1;
    end
    data_valid = 1'b1;
    data_in    = DATA_W'(a);
    @(negedge clk);
    checkOutput("ldA_valid", ldA, 1);
    checkOutput("busy_load", busy, 1);
    @(posedge clk); #1;
    for (int i = 0; i < wait_b; i++) begin
      data_valid = 1'b0;
      @(negedge clk);
      checkOutput("ldB_no_valid", ldB, 0);
      @(posedge clk); #1;
    end
    data_valid = 1'b1;
    data_in    = DATA_W'(b);
    @(negedge clk);
    checkOutput("ldB_valid", ldB, 1);
    @(posedge clk); #1;
    data_valid = 1'b0;
    data_in    = '0;
    if (poke_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (reset_after >= 0) begin
      repeat (reset_after) begin
        @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_ldA", ldA, 0);
      checkOutput("reset_ldB", ldB, 0);
      checkOutput("reset_done", done, 0);
      repeat (MAX_ITER + 4) @(negedge clk);
    end else begin
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) begin
        checks++;
        errors++;
        $display("[TB] FAIL done_timeout: got no done in 40 cycles, expected done");
      end
      repeat (3) begin
        @(negedge clk);
        checkOutput("idle_busy", busy, 0);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ldA", ldA, 0);
    checkOutput("rst_ldB", ldB, 0);
    checkOutput("rst_sel1", sel1, 0);
    checkOutput("rst_sel2", sel2, 0);
    checkOutput("rst_sel_in", sel_in, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
`ifdef GCD_CYCLE_COUNT_EN
    checkOutput("rst_iter_count", iter_count, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 12,8: A-=B then B-=A then eq; 2 subtractions, 4 cycles to the done cycle.
    applyStimulus(12, 8, 0, 0, 4, 4, 0, 4, 2, 1'b0, -1);
    // 7,7: immediate eq.
    applyStimulus(7, 7, 0, 0, 7, 7, 0, 2, 0, 1'b0, -1);
    // 0,5: B stays 5 forever; 8 ldB pulses, terminal cycle, then done with err.
    applyStimulus(0, 5, 0, 0, 0, 5, 1, 10, 8, 1'b0, -1);
    // 48,18 with valid gaps: 30,18 -> 12,18 -> 12,6 -> 6,6.
    applyStimulus(48, 18, 3, 2, 6, 6, 0, 6, 4, 1'b0, -1);
    // 100,3 aborted by reset, then 9,6: 3,6 -> 3,3.
    applyStimulus(100, 3, 0, 0, 0, 0, 0, 0, 0, 1'b0, 3);
    applyStimulus(9, 6, 0, 0, 3, 3, 0, 4, 2, 1'b0, -1);
    // start pulsed during S_ITER must not launch another operation.
    applyStimulus(12, 8, 0, 0, 4, 4, 0, 4, 2, 1'b1, -1);

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
